// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin arbiter for eight sources sharing one N-bit 8:1 mux.
// The winner is steered through the mux into a registered valid/ready output stage.
// A one-hot grant pulses back to the winning source on the edge that consumes its beat.
module rr_mux8_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d4,
  input  logic [N-1:0] d5,
  input  logic [N-1:0] d6,
  input  logic [N-1:0] d7,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [2:0]   out_src
);

  logic [2:0]   ptr;
  logic [2:0]   win;
  logic [N-1:0] mux_d;
  logic         load;

  // Round-robin search starting at ptr; falls back to ptr when nothing requests.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Shared 8:1 data mux steered by the arbitration result.
  always_comb begin
    mux_d = '0;
    case (win)
      3'd0: mux_d = d0;
      3'd1: mux_d = d1;
      3'd2: mux_d = d2;
      3'd3: mux_d = d3;
      3'd4: mux_d = d4;
      3'd5: mux_d = d5;
      3'd6: mux_d = d6;
      3'd7: mux_d = d7;
      default: mux_d = '0;
    endcase
  end

  // Load when someone requests and the output register is free or being drained;
  // grant is held off while reset is asserted.
  always_comb begin
    load = (|req) && (!out_valid || out_ready);
    sel  = win;
    gnt  = '0;
    if (load && rst_n)
      gnt = 8'b1 << win;
  end

  // Output register and priority pointer; out_valid encodes EMPTY/FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_d;
      out_src   <= win;
      ptr       <= win + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed testbench for rr_mux8_arbiter with hand-computed expectations.
module tb_rr_mux8_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_src;

  int vecs = 0;
  int errs = 0;

  rr_mux8_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source k presents data 15-k so data and index differ.
  function automatic logic [3:0] exp_data(input int k);
    return 4'(15 - k);
  endfunction

  function automatic logic [7:0] exp_gnt(input int k);
    return 8'(1 << k);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    #1;
    cyc();
    vecs++; if (gnt !== 8'h00) begin errs++; $display("FAIL rst_gnt: got %h want 00", gnt); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    vecs++; if (out_data !== 4'h0) begin errs++; $display("FAIL rst_data: got %h want 0", out_data); end
    vecs++; if (out_src !== 3'd0) begin errs++; $display("FAIL rst_src: got %0d want 0", out_src); end
    cyc();
    vecs++; if (gnt !== 8'h00) begin errs++; $display("FAIL rst_gnt_hold: got %h want 00", gnt); end
    rst_n = 1'b1;
    #1;
    vecs++; if (sel !== 3'd0) begin errs++; $display("FAIL rst_sel: got %0d want 0", sel); end
    vecs++; if (gnt !== 8'h01) begin errs++; $display("FAIL rst_first_gnt: got %h want 01", gnt); end
    cyc();
    vecs++; if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== exp_data(0)) begin
      errs++; $display("FAIL rst_first_beat: got v=%b src=%0d data=%h want v=1 src=0 data=%h",
                       out_valid, out_src, out_data, exp_data(0));
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      vecs++; if (gnt !== exp_gnt(i % 8)) begin errs++; $display("FAIL rot_gnt[%0d]: got %h want %h", i, gnt, exp_gnt(i % 8)); end
      cyc();
      vecs++; if (out_valid !== 1'b1 || out_src !== 3'(i % 8) || out_data !== exp_data(i % 8)) begin
        errs++; $display("FAIL rot_beat[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                         i, out_valid, out_src, out_data, i % 8, exp_data(i % 8));
      end
    end
  endtask

  task automatic test_wrap();
    int seq[6] = '{0, 2, 7, 0, 2, 7};
    do_reset();
    req = 8'b1000_0101;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vecs++; if (gnt !== exp_gnt(seq[i])) begin errs++; $display("FAIL wrap_gnt[%0d]: got %h want %h", i, gnt, exp_gnt(seq[i])); end
      cyc();
      vecs++; if (out_src !== 3'(seq[i]) || out_data !== exp_data(seq[i])) begin
        errs++; $display("FAIL wrap_beat[%0d]: got src=%0d data=%h want src=%0d data=%h",
                         i, out_src, out_data, seq[i], exp_data(seq[i]));
      end
    end
    req = '0;
    #1;
    vecs++; if (sel !== 3'd0) begin errs++; $display("FAIL wrap_ptr: got sel=%0d want 0", sel); end
    vecs++; if (gnt !== 8'h00) begin errs++; $display("FAIL wrap_idle_gnt: got %h want 00", gnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    #1;
    cyc();
    out_ready = 1'b0;
    #1;
    vecs++; if (gnt !== 8'h00) begin errs++; $display("FAIL bp_gnt0: got %h want 00", gnt); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++; if (gnt !== 8'h00 || sel !== 3'd1) begin
        errs++; $display("FAIL bp_hold_arb[%0d]: got gnt=%h sel=%0d want gnt=00 sel=1", i, gnt, sel);
      end
      vecs++; if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== exp_data(0)) begin
        errs++; $display("FAIL bp_hold_out[%0d]: got v=%b src=%0d data=%h want v=1 src=0 data=%h",
                         i, out_valid, out_src, out_data, exp_data(0));
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (gnt !== 8'h02) begin errs++; $display("FAIL bp_release_gnt: got %h want 02", gnt); end
    cyc();
    vecs++; if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== exp_data(1)) begin
      errs++; $display("FAIL bp_reload: got v=%b src=%0d data=%h want v=1 src=1 data=%h",
                       out_valid, out_src, out_data, exp_data(1));
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (gnt !== 8'h20 || sel !== 3'd5) begin
        errs++; $display("FAIL single_gnt[%0d]: got gnt=%h sel=%0d want gnt=20 sel=5", i, gnt, sel);
      end
      cyc();
      vecs++; if (out_valid !== 1'b1 || out_src !== 3'd5 || out_data !== exp_data(5)) begin
        errs++; $display("FAIL single_beat[%0d]: got v=%b src=%0d data=%h want v=1 src=5 data=%h",
                         i, out_valid, out_src, out_data, exp_data(5));
      end
    end
    req = '0;
    #1;
    vecs++; if (gnt !== 8'h00 || sel !== 3'd6 || out_valid !== 1'b1) begin
      errs++; $display("FAIL drain_pre: got gnt=%h sel=%0d v=%b want gnt=00 sel=6 v=1", gnt, sel, out_valid);
    end
    cyc();
    vecs++; if (out_valid !== 1'b0 || out_src !== 3'd5 || out_data !== exp_data(5)) begin
      errs++; $display("FAIL drain_post: got v=%b src=%0d data=%h want v=0 src=5 data=%h",
                       out_valid, out_src, out_data, exp_data(5));
    end
  endtask

  task automatic test_midreset();
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    #1;
    cyc();
    cyc();
    cyc();
    out_ready = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b1 || out_src !== 3'd2) begin
      errs++; $display("FAIL mid_pre: got v=%b src=%0d want v=1 src=2", out_valid, out_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0 || gnt !== 8'h00) begin
      errs++; $display("FAIL mid_rst: got v=%b data=%h src=%0d gnt=%h want v=0 data=0 src=0 gnt=00",
                       out_valid, out_data, out_src, gnt);
    end
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    vecs++; if (gnt !== 8'h01 || sel !== 3'd0) begin
      errs++; $display("FAIL mid_restart_gnt: got gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
    end
    cyc();
    vecs++; if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== exp_data(0)) begin
      errs++; $display("FAIL mid_restart_beat: got v=%b src=%0d data=%h want v=1 src=0 data=%h",
                       out_valid, out_src, out_data, exp_data(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    d0 = exp_data(0); d1 = exp_data(1); d2 = exp_data(2); d3 = exp_data(3);
    d4 = exp_data(4); d5 = exp_data(5); d6 = exp_data(6); d7 = exp_data(7);
    test_reset();
    test_rotation();
    test_wrap();
    test_backpressure();
    test_single();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
